// File: rtl/mux_sync_tx.sv
// mux_sync_tx: source side of a mux-enable clock-domain crossing.
// Holds a word stable, raises en_o, and runs a four-phase handshake against a synchronized ack.
module mux_sync_tx #(
    parameter int CHAIN_LENGTH = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  en_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ_HI = 2'd1,
        S_ACK_LO = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CHAIN_LENGTH-1:0] r_ack_sync;
    logic                    r_ack_s_q;
    logic                    r_en;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_err;
    logic                    w_ack_s;
    logic                    w_ack_rise;
    logic                    w_ready;
    logic                    w_busy;
    logic                    w_accept;
    logic                    w_done;

    assign w_ack_s    = r_ack_sync[CHAIN_LENGTH-1];
    assign w_ack_rise = w_ack_s & ~r_ack_s_q;

    // Ack synchronizer chain; the extra flop remembers ack_s for rise detection
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_ack_sync <= '0;
            r_ack_s_q  <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[CHAIN_LENGTH-2:0], ack_i};
            r_ack_s_q  <= w_ack_s;
        end
    end

    // Handshake state register
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: launch on accept, drop request on ack, finish when ack falls
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_REQ_HI;
            S_REQ_HI: if (w_ack_s)  w_state_nxt = S_ACK_LO;
            S_ACK_LO: if (!w_ack_s) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from registered state and synchronized ack only
    always_comb begin
        w_ready  = (r_state == S_IDLE) && !w_ack_s;
        w_busy   = (r_state != S_IDLE);
        w_accept = w_ready && valid_i;
        w_done   = (r_state == S_ACK_LO) && !w_ack_s;
    end

    // Registered request, payload, completion count and sticky error
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_en   <= 1'b0;
            r_data <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_en <= (w_state_nxt == S_REQ_HI);
            if (w_accept) begin
                r_data <= data_i;
            end
            if (w_done) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_ack_rise && (r_state != S_REQ_HI)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ready_o    = w_ready;
    assign busy_o     = w_busy;
    assign en_o       = r_en;
    assign data_o     = r_data;
    assign xfer_cnt_o = r_cnt;
    assign err_o      = r_err;

endmodule

// File: tb/tb_mux_sync_tx.sv
// tb_mux_sync_tx: table vectors, hand sequences and a random run
// against a queue-based model of the synchronized handshake.
module tb_mux_sync_tx;

    localparam int CL = 3;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          reset_ni;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          en_o;
    logic [DW-1:0] data_o;
    logic          ack_i;
    logic          busy_o;
    logic [CW-1:0] xfer_cnt_o;
    logic          err_o;

    int n_vec = 0;
    int n_err = 0;

    mux_sync_tx #(
        .CHAIN_LENGTH(CL),
        .DATA_WIDTH  (DW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .en_o      (en_o),
        .data_o    (data_o),
        .ack_i     (ack_i),
        .busy_o    (busy_o),
        .xfer_cnt_o(xfer_cnt_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 request high, 2 waiting for ack low.
    // hq holds ack_i samples; ack_s is the sample taken CL-1 edges earlier.
    int        m_phase;
    int        m_cnt;
    bit [31:0] m_data;
    bit        m_err;
    bit        hq[$];

    task automatic model_edge();
        bit s_old;
        bit s_prev;
        if (!reset_ni) begin
            m_phase = 0;
            m_cnt   = 0;
            m_data  = '0;
            m_err   = 1'b0;
            hq.delete();
            repeat (CL + 1) hq.push_back(1'b0);
        end else begin
            s_old  = hq[$-(CL-1)];
            s_prev = hq[$-CL];
            if (s_old && !s_prev && m_phase != 1) m_err = 1'b1;
            case (m_phase)
                0: if (valid_i && !s_old) begin
                    m_data  = data_i;
                    m_phase = 1;
                end
                1: if (s_old) m_phase = 2;
                default: if (!s_old) begin
                    m_phase = 0;
                    m_cnt   = (m_cnt + 1) % (1 << CW);
                end
            endcase
            hq.push_back(ack_i);
            if (hq.size() > CL + 1) void'(hq.pop_front());
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic a, input logic r);
        valid_i  = v;
        data_i   = d;
        ack_i    = a;
        reset_ni = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_xfer(input logic [31:0] w);
        int k;
        step(1'b1, w, 1'b0, 1'b1);
        k = 0;
        while (en_o !== 1'b1 && k < 20) begin
            step(1'b1, w, 1'b0, 1'b1);
            k++;
        end
        chk("xfer_accept", en_o, 1);
        k = 0;
        while (en_o === 1'b1 && k < 20) begin
            step(1'b0, w, 1'b1, 1'b1);
            k++;
        end
        chk("xfer_req_drop", en_o, 0);
        k = 0;
        while (busy_o === 1'b1 && k < 20) begin
            step(1'b0, w, 1'b0, 1'b1);
            k++;
        end
        chk("xfer_done", busy_o, 0);
        chk("xfer_data", data_o, w);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        a;
        logic        en;
        logic        rdy;
        logic        busy;
        logic [3:0]  cnt;
        logic [31:0] dout;
        logic        err;
    } vec_t;

    vec_t tbl[15];

    logic        r_v;
    logic [31:0] r_w;
    logic        r_a;
    logic        r_took;

    initial begin
        // Basic transfer with back-pressure; row i is edge Ei
        tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0};
        for (int i = 1; i <= 4; i++)
            tbl[i] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0};
        for (int i = 5; i <= 7; i++)
            tbl[i] = '{1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0};
        for (int i = 8; i <= 9; i++)
            tbl[i] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0};
        for (int i = 10; i <= 12; i++)
            tbl[i] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0};
        tbl[13] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'hDEADBEEF, 1'b0};
        tbl[14] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h12345678, 1'b0};

        valid_i  = 1'b0;
        data_i   = '0;
        ack_i    = 1'b0;
        reset_ni = 1'b0;

        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'hFFFF0000, 1'b1, 1'b0);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_en", en_o, 0);
        chk("rst_cnt", xfer_cnt_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_err", err_o, 0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].a, 1'b1);
            chk($sformatf("tbl%0d_en", i), en_o, tbl[i].en);
            chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
            chk($sformatf("tbl%0d_cnt", i), xfer_cnt_o, tbl[i].cnt);
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].dout);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].err);
        end

        // Reset during REQ_HI aborts the transfer
        step(1'b1, 32'h0BADF00D, 1'b0, 1'b0);
        chk("midrst_en", en_o, 0);
        chk("midrst_data", data_o, 0);
        chk("midrst_cnt", xfer_cnt_o, 0);
        chk("midrst_ready", ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        do_xfer(32'hCAFEF00D);
        chk("midrst_after_cnt", xfer_cnt_o, 1);

        // Counter wrap over 17 back-to-back transfers
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            do_xfer(32'h10000000 + i);
            chk($sformatf("wrap_cnt%0d", i), xfer_cnt_o, (i + 1) % 16);
        end

        // Reset low between edges only must do nothing
        reset_ni = 1'b0;
        #2;
        reset_ni = 1'b1;
        chk("glitch_cnt_now", xfer_cnt_o, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("glitch_cnt", xfer_cnt_o, 1);
        chk("glitch_data", data_o, 32'h10000010);
        chk("glitch_ready", ready_o, 1);
        chk("glitch_err", err_o, 0);

        // Spurious ack pulse while idle
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("perr_ready_pre", ready_o, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("perr_ready_acks", ready_o, 0);
        chk("perr_err_pre", err_o, 0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("perr_err_set", err_o, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("perr_ready_hold", ready_o, 0);
        chk("perr_busy", busy_o, 0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("perr_ready_back", ready_o, 1);
        chk("perr_err_sticky", err_o, 1);
        chk("perr_cnt", xfer_cnt_o, 1);

        // Random traffic against the model
        r_v    = 1'b0;
        r_w    = $urandom;
        r_a    = 1'b0;
        r_took = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!r_v || r_took) begin
                r_v = ($urandom_range(0, 2) != 0);
                r_w = $urandom;
            end
            if (r_a != en_o && $urandom_range(0, 3) == 0) r_a = en_o;
            else if ($urandom_range(0, 199) == 0) r_a = ~r_a;
            r_took = r_v && ready_o;
            step(r_v, r_w, r_a, 1'b1);
            chk("rnd_en", en_o, (m_phase == 1));
            chk("rnd_busy", busy_o, (m_phase != 0));
            chk("rnd_ready", ready_o, (m_phase == 0) && !hq[$-(CL-1)]);
            chk("rnd_cnt", xfer_cnt_o, m_cnt);
            chk("rnd_data", data_o, m_data);
            chk("rnd_err", err_o, m_err);
        end
        chk("final_err", err_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
